// File: rtl/instr_register_param_if.sv
// Bus bundle for instr_register_param: the write handshake, the write
// payload, the read address and the registered read fields.
// Handshake: a write transfers on a rising clk edge where wr_valid and
// wr_ready are both 1; the master holds its payload stable while it waits;
// wr_ready never depends on wr_valid.
interface instr_register_param_if #(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
);
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int RES_WIDTH = 2 * OP_WIDTH;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [2:0]           opcode;
  logic [OP_WIDTH-1:0]  operand_a;
  logic [OP_WIDTH-1:0]  operand_b;
  logic [ADDR_W-1:0]    write_pointer;
  logic [ADDR_W-1:0]    read_pointer;
  logic [2:0]           rd_opc;
  logic [OP_WIDTH-1:0]  rd_op_a;
  logic [OP_WIDTH-1:0]  rd_op_b;
  logic [RES_WIDTH-1:0] rd_rez;
  logic                 rd_err;

  modport master (
    output wr_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
    input  wr_ready, rd_opc, rd_op_a, rd_op_b, rd_rez, rd_err
  );

  modport slave (
    input  wr_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
    output wr_ready, rd_opc, rd_op_a, rd_op_b, rd_rez, rd_err
  );
endinterface

// File: rtl/instr_register_param.sv
// Instruction register file: each write stores opcode, operands and the
// computed result. Single-cycle ops are written on the handshake edge.
// With macro INSTR_REG_DIV_EN defined, DIV/MOD by a non-zero divisor run a
// bit-serial restoring divider (one quotient bit per cycle) and write the
// entry afterwards; without it DIV/MOD write rez=0, err=1 at once.
// Reads are registered, read-before-write, zero for out-of-range addresses.
// dbg_state_o exposes the FSM state.
module instr_register_param #(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_register_param_if.slave bus,
  output logic [1:0]            dbg_state_o
);
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int RES_WIDTH = 2 * OP_WIDTH;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

`ifdef INSTR_REG_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV_RUN = 2'd1, DIV_WRITE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0} state_t;
`endif

  function automatic logic [RES_WIDTH-1:0] sext(input logic [OP_WIDTH-1:0] v);
    return {{OP_WIDTH{v[OP_WIDTH-1]}}, v};
  endfunction

  logic [2:0]           opc_q [DEPTH];
  logic [OP_WIDTH-1:0]  a_q   [DEPTH];
  logic [OP_WIDTH-1:0]  b_q   [DEPTH];
  logic [RES_WIDTH-1:0] rez_q [DEPTH];
  logic                 err_q [DEPTH];

  state_t               state_q, state_d;
  logic                 handshake;
  logic [RES_WIDTH-1:0] imm_rez;
  logic                 imm_err;
  logic                 wr_en, wr_hit;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [2:0]           wr_opc;
  logic [OP_WIDTH-1:0]  wr_a, wr_b;
  logic [RES_WIDTH-1:0] wr_rez;
  logic                 wr_err;

  assign bus.wr_ready = (state_q == IDLE) && !reset;
  assign handshake    = bus.wr_valid && bus.wr_ready;
  assign dbg_state_o  = state_q;
  assign wr_hit       = wr_en && ({1'b0, wr_ptr} < DEPTH_W);

`ifdef INSTR_REG_DIV_EN
  localparam int CNT_W = $clog2(OP_WIDTH + 1);
  localparam logic [OP_WIDTH-1:0] MIN_NEG = {1'b1, {(OP_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]     cnt_q;
  logic [OP_WIDTH-1:0]  quo_q, rem_q, dvs_q, cap_a_q, cap_b_q;
  logic [2:0]           cap_opc_q;
  logic [ADDR_W-1:0]    cap_ptr_q;
  logic                 div_start, last_step, fits;
  logic [OP_WIDTH:0]    trial;
  logic [OP_WIDTH-1:0]  q_signed, r_signed;
  logic [RES_WIDTH-1:0] div_rez;
  logic                 div_err;

  function automatic logic [OP_WIDTH-1:0] mag(input logic [OP_WIDTH-1:0] v);
    return v[OP_WIDTH-1] ? (~v + OP_WIDTH'(1)) : v;
  endfunction

  assign div_start = handshake && ((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD))
                     && (bus.operand_b != '0);
  assign last_step = (cnt_q == CNT_W'(OP_WIDTH - 1));
  // Dividend bits shift out of quo_q's top into the partial remainder.
  assign trial     = {rem_q, quo_q[OP_WIDTH-1]};
  assign fits      = (trial >= {1'b0, dvs_q});
  // Quotient negative when signs differ; remainder follows the dividend.
  assign q_signed  = (cap_a_q[OP_WIDTH-1] ^ cap_b_q[OP_WIDTH-1]) ? (~quo_q + OP_WIDTH'(1)) : quo_q;
  assign r_signed  = cap_a_q[OP_WIDTH-1] ? (~rem_q + OP_WIDTH'(1)) : rem_q;
  assign div_rez   = (cap_opc_q == OP_DIV) ? sext(q_signed) : sext(r_signed);
  assign div_err   = (cap_opc_q == OP_DIV) && (cap_a_q == MIN_NEG) && (cap_b_q == '1);

  // Divider datapath: capture on start, one restoring step per DIV_RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      cap_opc_q <= OP_ZERO;
      cap_ptr_q <= '0;
    end else if (div_start) begin
      cnt_q     <= '0;
      quo_q     <= mag(bus.operand_a);
      rem_q     <= '0;
      dvs_q     <= mag(bus.operand_b);
      cap_a_q   <= bus.operand_a;
      cap_b_q   <= bus.operand_b;
      cap_opc_q <= bus.opcode;
      cap_ptr_q <= bus.write_pointer;
    end else if (state_q == DIV_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      quo_q <= {quo_q[OP_WIDTH-2:0], fits};
      rem_q <= fits ? (trial[OP_WIDTH-1:0] - dvs_q) : trial[OP_WIDTH-1:0];
    end
  end
`endif

  // Single-cycle result; DIV/MOD here only cover the error outcome.
  always_comb begin
    imm_rez = '0;
    imm_err = 1'b0;
    case (bus.opcode)
      OP_ZERO:  imm_rez = '0;
      OP_PASSA: imm_rez = sext(bus.operand_a);
      OP_PASSB: imm_rez = sext(bus.operand_b);
      OP_ADD:   imm_rez = sext(bus.operand_a) + sext(bus.operand_b);
      OP_SUB:   imm_rez = sext(bus.operand_a) - sext(bus.operand_b);
      OP_MULT:  imm_rez = sext(bus.operand_a) * sext(bus.operand_b);
      default:  imm_err = 1'b1;
    endcase
  end

  // FSM next state and the single write port selection.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_ptr  = bus.write_pointer;
    wr_opc  = bus.opcode;
    wr_a    = bus.operand_a;
    wr_b    = bus.operand_b;
    wr_rez  = imm_rez;
    wr_err  = imm_err;
    case (state_q)
      IDLE: begin
`ifdef INSTR_REG_DIV_EN
        if (div_start)      state_d = DIV_RUN;
        else if (handshake) wr_en   = 1'b1;
`else
        if (handshake)      wr_en   = 1'b1;
`endif
      end
`ifdef INSTR_REG_DIV_EN
      DIV_RUN: begin
        if (last_step) state_d = DIV_WRITE;
      end
      DIV_WRITE: begin
        state_d = IDLE;
        wr_en   = 1'b1;
        wr_ptr  = cap_ptr_q;
        wr_opc  = cap_opc_q;
        wr_a    = cap_a_q;
        wr_b    = cap_b_q;
        wr_rez  = div_rez;
        wr_err  = div_err;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Entry storage: cleared on reset, one write per cycle when in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i] <= OP_ZERO;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        rez_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else if (wr_hit) begin
      opc_q[wr_ptr] <= wr_opc;
      a_q[wr_ptr]   <= wr_a;
      b_q[wr_ptr]   <= wr_b;
      rez_q[wr_ptr] <= wr_rez;
      err_q[wr_ptr] <= wr_err;
    end
  end

  // Registered read port; sees the entry value from before a same-edge write.
  always_ff @(posedge clk) begin
    if (reset || ({1'b0, bus.read_pointer} >= DEPTH_W)) begin
      bus.rd_opc  <= OP_ZERO;
      bus.rd_op_a <= '0;
      bus.rd_op_b <= '0;
      bus.rd_rez  <= '0;
      bus.rd_err  <= 1'b0;
    end else begin
      bus.rd_opc  <= opc_q[bus.read_pointer];
      bus.rd_op_a <= a_q[bus.read_pointer];
      bus.rd_op_b <= b_q[bus.read_pointer];
      bus.rd_rez  <= rez_q[bus.read_pointer];
      bus.rd_err  <= err_q[bus.read_pointer];
    end
  end
endmodule

// File: tb/tb_instr_register_param.sv
// Bench for instr_register_param: directed scenarios plus random traffic.
// A behavioural model (signed 64-bit arithmetic, entry array, busy countdown)
// predicts every read; reads push expectations into exp_q and a monitor pops
// them when the registered read data appears. A second small instance
// (DEPTH=20) covers out-of-range pointers.
module tb_instr_register_param;
  localparam int OPW = 32;
  localparam int DEP = 32;
  localparam longint MINV = -64'sd2147483648;

  typedef struct packed {
    logic [2:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] rez;
    logic        err;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  instr_register_param_if #(.OP_WIDTH(OPW), .DEPTH(DEP)) bus ();
  instr_register_param #(.OP_WIDTH(OPW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
  );

  logic rst_s;
  logic [1:0] dbg_s;
  instr_register_param_if #(.OP_WIDTH(OPW), .DEPTH(20)) bus_s ();
  instr_register_param #(.OP_WIDTH(OPW), .DEPTH(20)) dut_s (
    .clk(clk), .reset(rst_s), .bus(bus_s), .dbg_state_o(dbg_s)
  );

  int total = 0;
  int bad   = 0;
  logic [131:0] exp_q[$];
  ent_t model [DEP];
  int   busy = 0;
  ent_t pend;
  int   pend_ptr = 0;
  logic rd_issue = 1'b0;
  logic rd_fire_q = 1'b0;
  ent_t got_e, want_e;

  // reference model
  function automatic ent_t ref_op(input logic [2:0] op, input logic signed [31:0] a,
                                  input logic signed [31:0] b);
    ent_t e;
    longint r;
    logic er;
    r = 0;
    er = 1'b0;
    case (op)
      3'd0: r = 0;
      3'd1: r = a;
      3'd2: r = b;
      3'd3: r = longint'(a) + longint'(b);
      3'd4: r = longint'(a) - longint'(b);
      3'd5: r = longint'(a) * longint'(b);
      default: begin
`ifdef INSTR_REG_DIV_EN
        if (b == 0) er = 1'b1;
        else if (op == 3'd6) begin
          if (longint'(a) == MINV && b == -1) begin r = MINV; er = 1'b1; end
          else r = longint'(a) / longint'(b);
        end else r = longint'(a) % longint'(b);
`else
        er = 1'b1;
`endif
      end
    endcase
    e.opc = op; e.a = a; e.b = b; e.rez = r; e.err = er;
    return e;
  endfunction

  function automatic bit multi_cycle(input logic [2:0] op, input logic [31:0] b);
`ifdef INSTR_REG_DIV_EN
    return (op >= 3'd6) && (b != 0);
`else
    return (op == 3'd7) && (b == 32'd1) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // driver: one clock cycle of stimulus, ready check, model update
  task automatic step(input logic rst, input logic wv, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] wp,
                      input logic rv, input logic [4:0] rp);
    logic exp_rdy;
    ent_t e;
    reset             = rst;
    bus.wr_valid      = wv;
    bus.opcode        = op;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.write_pointer = wp;
    bus.read_pointer  = rp;
    rd_issue          = rv;
    if (rv) exp_q.push_back(rst ? '0 : model[rp]);
    exp_rdy = !rst && (busy == 0);
    #1;
    total++;
    if (bus.wr_ready !== exp_rdy) begin
      bad++;
      $display("FAIL wr_ready t=%0t got=%b want=%b", $time, bus.wr_ready, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = '0;
      busy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) model[pend_ptr] = pend;
    end else if (wv) begin
      e = ref_op(op, a, b);
      if (multi_cycle(op, b)) begin busy = OPW + 1; pend = e; pend_ptr = int'(wp); end
      else model[wp] = e;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] wp);
    step(1'b0, 1'b1, op, a, b, wp, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] rp);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, rp);
  endtask

  // while busy, keep offering junk writes (must be ignored) and random reads
  task automatic drain();
    int guard;
    guard = 0;
    while (busy > 0 && guard < 100) begin
      step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      guard++;
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) rd_fire_q <= rd_issue;

  always @(posedge clk) begin
    #1;
    if (rd_fire_q) begin
      total++;
      got_e = {bus.rd_opc, bus.rd_op_a, bus.rd_op_b, bus.rd_rez, bus.rd_err};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow t=%0t got=%h want=none", $time, got_e);
      end else begin
        want_e = exp_q.pop_front();
        if (got_e !== want_e) begin
          bad++;
          $display("FAIL rd_entry t=%0t got opc=%0d a=%h b=%h rez=%h err=%b want opc=%0d a=%h b=%h rez=%h err=%b",
                   $time, got_e.opc, got_e.a, got_e.b, got_e.rez, got_e.err,
                   want_e.opc, want_e.a, want_e.b, want_e.rez, want_e.err);
        end
      end
    end
  end

  // main sequence
  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.opcode = 3'd0; bus.operand_a = '0; bus.operand_b = '0;
    bus.write_pointer = '0; bus.read_pointer = '0;
    foreach (model[i]) model[i] = '0;
    pend = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 3'd0, 0, 0, 5'd0, 1'b0, 5'd5);
    step(1'b1, 1'b1, 3'd1, 32'd77, 0, 5'd5, 1'b1, 5'd5);   // reset wins over handshake
    rd(5'd5);
    // single-cycle ops
    wr(3'd3, 32'd7, -32'd3, 5'd2);
    wr(3'd5, 32'd100000, -32'd70000, 5'd3);
    rd(5'd2);
    rd(5'd3);
    wr(3'd4, -32'd5, 32'd9, 5'd11);
    wr(3'd1, 32'hDEAD_BEEF, 32'd1, 5'd12);
    wr(3'd0, 32'd3, 32'd4, 5'd13);
    rd(5'd11); rd(5'd12); rd(5'd13);
    // iterative divide / modulo
    wr(3'd6, -32'd7, 32'd2, 5'd4);
    drain();
    wr(3'd7, -32'd7, 32'd2, 5'd5);
    drain();
    rd(5'd4); rd(5'd5);
    // divide by zero writes at once
    wr(3'd6, 32'd5, 32'd0, 5'd6);
    rd(5'd6);
    wr(3'd7, 32'd5, 32'd0, 5'd14);
    rd(5'd14);
    // overflow case and its modulo partner
    wr(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    drain();
    wr(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    drain();
    wr(3'd6, 32'd100, -32'd3, 5'd15);
    drain();
    rd(5'd9); rd(5'd10); rd(5'd15);
    // reset aborts a division in flight
    wr(3'd1, 32'd9, 32'd0, 5'd7);
    rd(5'd7);
    wr(3'd6, 32'd100, 32'd3, 5'd7);
    for (int i = 0; i < 9; i++) rd(5'd7);
    step(1'b1, 1'b0, 3'd0, 0, 0, 5'd0, 1'b0, 5'd0);
    rd(5'd7);
    // read-before-write on the same edge
    step(1'b0, 1'b1, 3'd2, 32'd0, 32'd11, 5'd8, 1'b1, 5'd8);
    rd(5'd8);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           pick(), pick(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)));
    end
    drain();
    for (int i = 0; i < DEP; i++) rd(5'(i));
    rd(5'd0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // small instance: out-of-range write and read pointers
  task automatic chk_s(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    rst_s = 1'b1;
    bus_s.wr_valid = 1'b0; bus_s.opcode = 3'd0; bus_s.operand_a = '0; bus_s.operand_b = '0;
    bus_s.write_pointer = '0; bus_s.read_pointer = '0;
    @(negedge clk); @(negedge clk);
    rst_s = 1'b0;
    bus_s.wr_valid = 1'b1; bus_s.opcode = 3'd1; bus_s.operand_a = 32'd5; bus_s.write_pointer = 5'd25;
    bus_s.read_pointer = 5'd25;
    @(negedge clk);
    chk_s("small_oor_read", bus_s.rd_rez, 64'd0);
    chk_s("small_oor_ready", 64'(bus_s.wr_ready), 64'd1);
    bus_s.operand_a = 32'd6; bus_s.write_pointer = 5'd19; bus_s.read_pointer = 5'd19;
    @(negedge clk);
    chk_s("small_rbw", bus_s.rd_rez, 64'd0);
    bus_s.wr_valid = 1'b0;
    @(negedge clk);
    chk_s("small_last_rez", bus_s.rd_rez, 64'd6);
    chk_s("small_last_opc", 64'(bus_s.rd_opc), 64'd1);
    bus_s.read_pointer = 5'd25;
    @(negedge clk);
    chk_s("small_oor_after_wr", bus_s.rd_rez, 64'd0);
    chk_s("small_oor_opc", 64'(bus_s.rd_opc), 64'd0);
  end
endmodule
